clk_rate_ctrl: RTL
==================

# clk_rate_ctrl

Run/pause/single-step controller for the demo-board slow-clock path. It turns button presses into a selectable-rate, one-cycle `tick` clock-enable, so downstream logic runs on `clk` instead of a divided clock. It replaces counter-bit clock selection with an enable that can be sped up, slowed down, paused and single-stepped. It sits between the board buttons and every block that advances on the demo clock.

## Interface
- `DIV_POW_FASTEST`, 1: minimum rate exponent; tick period is 2**`DIV_POW_FASTEST` cycles.
- `DIV_POW_SLOWEST`, 26: maximum rate exponent and reset rate. 50 MHz / 2**26 gives about 0.75 Hz.
- `DEBOUNCE_POW`, 16: debounce window of 2**`DEBOUNCE_POW` cycles (used only with the debounce macro).
- `clk`, in, 1: single clock for the whole block.
- `rst_n`, in, 1: asynchronous active-low reset.
- `btn_faster`, in, 1: raw button, active-high, asynchronous to `clk`.
- `btn_slower`, in, 1: raw button, active-high, asynchronous.
- `btn_pause`, in, 1: raw button, active-high, asynchronous.
- `btn_step`, in, 1: raw button, active-high, asynchronous.
- `tick`, out, 1: one-cycle clock-enable strobe.
- `rate_pow`, out, $clog2(`DIV_POW_SLOWEST`+1): current rate exponent.
- `paused`, out, 1: high when the FSM is in PAUSED or STEP.

## Operation
- **Reset values:** `tick`=0, `rate_pow`=`DIV_POW_SLOWEST`, `paused`=0, FSM=RUN, counter=0. Synchronizer, filter and edge-detect flops are all 0.
- **Input path, per button:**
  - 2-flop synchronizer, then filter (see Configuration), then rising-edge detect.
  - The edge detect produces a one-cycle press event.
- **Rate control:**
  - A faster event decrements `rate_pow`, saturating at `DIV_POW_FASTEST`.
  - A slower event increments `rate_pow`, saturating at `DIV_POW_SLOWEST`.
  - Faster and slower events in the same cycle: no change.
  - Any actual change of `rate_pow` clears the counter to 0, in any state.
  - A saturated press leaves the counter untouched.
- **Counter:**
  - `DIV_POW_SLOWEST` bits wide; increments every cycle in RUN and holds in PAUSED/STEP.
  - Wraps modulo 2**`DIV_POW_SLOWEST`.
- **FSM states:** RUN, PAUSED, STEP.
  - RUN → PAUSED on a pause event.
  - PAUSED → RUN on a pause event. The counter resumes from its frozen value.
  - PAUSED → STEP on a step event without a pause event in the same cycle. If both arrive together, pause wins and the step is dropped.
  - STEP → PAUSED unconditionally after one cycle. Events arriving while in STEP are ignored, except rate events.
  - A step event in RUN is ignored.
- **tick (combinational from registers):**
  - (state==RUN and counter[`rate_pow`-1:0] all ones), or (state==STEP).
  - Never high for two consecutive cycles, except in RUN with `rate_pow`=0 (not reachable when `DIV_POW_FASTEST`≥1).

## Timing
- **RUN tick period:** exactly 2**`rate_pow` cycles.
  - After reset release, the first tick is in cycle 2**`DIV_POW_SLOWEST` (counting the first post-reset cycle as 1).
  - After a rate change, the first tick comes 2**(new `rate_pow`) cycles after the cycle in which `rate_pow` updated.
- **Press-to-event latency:** raw button high before edge 1 gives a press event during the cycle after edge 2, with no debounce. Debounce adds 2**`DEBOUNCE_POW` cycles.
- **State and rate latency:** `rate_pow` and FSM state update at the edge following the event cycle.
- **Step latency:** `tick` goes high in the cycle after edge 3 and lasts exactly 1 cycle.
- **Reset mid-operation:**
  - Asserting `rst_n` low forces all reset values immediately, asynchronously.
  - A button held through reset release produces no event until it is released and pressed again.

## Configuration
- `CLK_RATE_CTRL_DEBOUNCE_EN` **defined:** each synchronized button passes through a per-button counter.
  - The filtered level changes only after the synchronized level differs from it for 2**`DEBOUNCE_POW` consecutive cycles.
  - Any bounce restarts the count.
- **Undefined:** filtered level = synchronized level, and `DEBOUNCE_POW` is unused.

## Test plan
Parameters for all scenarios: `DIV_POW_FASTEST`=1, `DIV_POW_SLOWEST`=4, `DEBOUNCE_POW`=3.
- **Reset, idle buttons, 100 cycles** → `rate_pow`=4; ticks in cycles 16, 32, 48…; `paused`=0.
- **4 faster presses** → `rate_pow` steps 3, 2, 1, 1 (saturates); tick every 2 cycles; the counter clears on the first three presses only.
- **Pause, wait 50 cycles, step ×2, pause** → no RUN ticks while paused; exactly 2 single-cycle ticks, each in the cycle after edge 3 from its press; RUN ticks resume from the frozen counter.
- **Faster and slower events in the same cycle; pause and step in the same cycle while PAUSED** → `rate_pow` unchanged; FSM goes to RUN with no step tick.
- **Reset asserted while PAUSED at `rate_pow`=2** → immediately RUN, `rate_pow`=4, `tick`=0, counter 0; next tick in cycle 16.
- **`CLK_RATE_CTRL_DEBOUNCE_EN` defined** → a 5-cycle step glitch while paused gives no tick; a 20-cycle press gives exactly one tick.

Source files
------------

// File: rtl/clk_rate_ctrl.sv
// Run/pause/single-step controller: turns four raw buttons into a rate-selectable one-cycle tick enable.
// Optional per-button debounce filter is enabled by defining CLK_RATE_CTRL_DEBOUNCE_EN.
module clk_rate_ctrl #(
   parameter int DIV_POW_FASTEST = 1,
   parameter int DIV_POW_SLOWEST = 26,
   parameter int DEBOUNCE_POW    = 16
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 btn_faster,
   input  logic                                 btn_slower,
   input  logic                                 btn_pause,
   input  logic                                 btn_step,
   output logic                                 tick,
   output logic [$clog2(DIV_POW_SLOWEST+1)-1:0] rate_pow,
   output logic                                 paused
);

   localparam int RW = $clog2(DIV_POW_SLOWEST + 1);
   localparam int CW = DIV_POW_SLOWEST;
   localparam int NB = 4;

   localparam int B_FASTER = 0;
   localparam int B_SLOWER = 1;
   localparam int B_PAUSE  = 2;
   localparam int B_STEP   = 3;

   localparam logic [RW-1:0] RATE_MIN = RW'(DIV_POW_FASTEST);
   localparam logic [RW-1:0] RATE_MAX = RW'(DIV_POW_SLOWEST);
   localparam logic [RW-1:0] RATE_ONE = RW'(1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      S_RUN    = 2'd0,
      S_PAUSED = 2'd1,
      S_STEP   = 2'd2
   } state_t;

   if (DIV_POW_FASTEST < 1 || DIV_POW_FASTEST > DIV_POW_SLOWEST || DEBOUNCE_POW < 1) begin : g_param_check
      $error("clk_rate_ctrl: inconsistent rate or debounce parameters");
   end

   logic [NB-1:0] raw_btn;
   logic [NB-1:0] sync1;
   logic [NB-1:0] sync2;
   logic [NB-1:0] filt;
   logic [NB-1:0] prev;
   logic [NB-1:0] armed;
   logic [1:0]    sync_vld;
   logic [NB-1:0] press;

   logic          ev_faster;
   logic          ev_slower;
   logic          ev_pause;
   logic          ev_step;
   logic          rate_up;
   logic          rate_dn;

   logic [CW-1:0] cnt;
   logic [CW-1:0] mask;
   logic          run_hit;

   state_t        state;
   state_t        state_nxt;

   assign raw_btn = {btn_step, btn_pause, btn_slower, btn_faster};

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= raw_btn;
         sync2 <= sync1;
      end
   end

`ifdef CLK_RATE_CTRL_DEBOUNCE_EN
   localparam logic [DEBOUNCE_POW-1:0] DB_LAST = '1;
   localparam logic [DEBOUNCE_POW-1:0] DB_ONE  = DEBOUNCE_POW'(1);

   logic [DEBOUNCE_POW-1:0] db_cnt [NB];

   // NOTE: the debounce counters are plain flops, not RAM, so they are reset like any other state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filt <= '0;
         for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NB; i++) begin
            if (sync2[i] == filt[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               filt[i]   <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DB_ONE;
            end
         end
      end
   end
`else
   assign filt = sync2;
`endif

   // A button only arms once the synchronizer has flushed and shown it released,
   // so a button held across reset release never produces a press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev     <= '0;
         armed    <= '0;
         sync_vld <= '0;
      end else begin
         prev     <= filt;
         armed    <= armed | (~sync2 & {NB{sync_vld[1]}});
         sync_vld <= {sync_vld[0], 1'b1};
      end
   end

   assign press     = filt & ~prev & armed;
   assign ev_faster = press[B_FASTER];
   assign ev_slower = press[B_SLOWER];
   assign ev_pause  = press[B_PAUSE];
   assign ev_step   = press[B_STEP];

   assign rate_dn = ev_faster & ~ev_slower & (rate_pow > RATE_MIN);
   assign rate_up = ev_slower & ~ev_faster & (rate_pow < RATE_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rate_pow <= RATE_MAX;
      end else if (rate_dn) begin
         rate_pow <= rate_pow - RATE_ONE;
      end else if (rate_up) begin
         rate_pow <= rate_pow + RATE_ONE;
      end
   end

   // Restart the period on a real rate change so the first tick lands a full new period later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (rate_dn || rate_up) begin
         cnt <= '0;
      end else if (state == S_RUN) begin
         cnt <= cnt + CNT_ONE;
      end
   end

   always_comb begin
      mask = '0;
      for (int i = 0; i < CW; i++) mask[i] = (i < int'(rate_pow));
   end

   assign run_hit = ((cnt & mask) == mask);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_RUN;
      else        state <= state_nxt;
   end

   // NOTE: default assignment first so no path through the case leaves state_nxt unassigned (no latch).
   always_comb begin
      state_nxt = state;
      case (state)
         S_RUN: begin
            if (ev_pause) state_nxt = S_PAUSED;
         end
         S_PAUSED: begin
            if (ev_pause)     state_nxt = S_RUN;
            else if (ev_step) state_nxt = S_STEP;
         end
         S_STEP:  state_nxt = S_PAUSED;
         default: state_nxt = S_RUN;
      endcase
   end

   always_comb begin
      tick   = 1'b0;
      paused = 1'b0;
      case (state)
         S_RUN:    tick = run_hit;
         S_PAUSED: paused = 1'b1;
         S_STEP: begin
            tick   = 1'b1;
            paused = 1'b1;
         end
         default: begin
            tick   = 1'b0;
            paused = 1'b0;
         end
      endcase
   end

endmodule
